// File: rtl/fill_xcel_pkg.sv
// Shared types and constants for the fill accelerator.
package fill_xcel_pkg;
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} fill_state_t;

    localparam int   WORD_BYTES     = 4;
    localparam int   ADDR_LSB       = $clog2(WORD_BYTES);
    localparam int   SIZE_W         = 7;
    localparam logic MEM_TYPE_WRITE = 1'b1;
endpackage

// File: rtl/fill_xcel_dpath.sv
// Fill datapath: index counter, value/step adder, checksum accumulator and
// word-address generation. Registers load on load_i and advance on commit_i.
module fill_xcel_dpath
    import fill_xcel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              commit_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [31:0]       start_i,
    input  logic [31:0]       step_i,
    output logic              last_o,
    output logic [31:0]       addr_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       result_o
);
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] idx_q,  idx_d;
    logic [31:0]       val_q,  val_d;
    logic [31:0]       step_q, step_d;
    logic [31:0]       res_q,  res_d;

    always_comb begin
        size_d = size_q;
        idx_d  = idx_q;
        val_d  = val_q;
        step_d = step_q;
        res_d  = res_q;
        if (load_i) begin
            size_d = size_i;
            idx_d  = '0;
            val_d  = start_i;
            step_d = step_i;
            res_d  = '0;
        end else if (commit_i) begin
            idx_d = idx_q + 1'b1;
            val_d = val_q + step_q;
            res_d = res_q + val_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q <= '0;
            idx_q  <= '0;
            val_q  <= '0;
            step_q <= '0;
            res_q  <= '0;
        end else begin
            size_q <= size_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            step_q <= step_d;
            res_q  <= res_d;
        end
    end

    assign last_o   = (idx_q == size_q - 1'b1);
    assign addr_o   = {{(32-SIZE_W-ADDR_LSB){1'b0}}, idx_q, ADDR_LSB'(0)};
    assign wdata_o  = val_q;
    assign result_o = res_q;
endmodule

// File: rtl/fill_xcel.sv
// Memory-fill accelerator top: request handshake FSM and write-commit logic.
// Define FILL_XCEL_WAIT_EN to honour mem_wait stalls; otherwise it is ignored.
module fill_xcel
    import fill_xcel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [31:0]       in_start,
    input  logic [31:0]       in_step,
    output logic              mem_val,
    input  logic              mem_wait,
    output logic              mem_type,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       result
);
    fill_state_t state_q, state_d;
    logic        accept;
    logic        commit;
    logic        last;

    assign in_rdy   = (state_q == IDLE);
    assign mem_val  = (state_q == WRITE);
    assign mem_type = MEM_TYPE_WRITE;
    assign accept   = in_val && in_rdy;

`ifdef FILL_XCEL_WAIT_EN
    assign commit = mem_val && !mem_wait;
`else
    logic unused_wait;
    assign unused_wait = mem_wait;
    assign commit      = mem_val;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && in_size != '0) state_d = WRITE;
            WRITE:   if (commit && last)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A zero-size request still loads, which clears the checksum.
    fill_xcel_dpath u_dpath (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .commit_i (commit),
        .size_i   (in_size),
        .start_i  (in_start),
        .step_i   (in_step),
        .last_o   (last),
        .addr_o   (mem_addr),
        .wdata_o  (mem_wdata),
        .result_o (result)
    );
endmodule
